// File: rtl/alu_shift_issue_if.sv
// Handshake bundle between the upstream issue source and the shift issue stage,
// plus the decoded head beat presented to the shifter/ALU.
interface alu_shift_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_a;
    logic [4:0]  in_shamt;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_shiftamt;
    logic        out_shift_in;
    logic        out_dir;
    logic        out_is_shift;

    modport master (
        output in_valid, in_op, in_a, in_shamt, out_ready,
        input  in_ready, out_valid, out_data, out_shiftamt, out_shift_in, out_dir, out_is_shift
    );

    modport slave (
        input  in_valid, in_op, in_a, in_shamt, out_ready,
        output in_ready, out_valid, out_data, out_shiftamt, out_shift_in, out_dir, out_is_shift
    );
endinterface

// File: rtl/alu_shift_issue.sv
// Shift issue stage: decodes SLL/SRA beats into shifter controls at accept time,
// buffers up to two beats in a skid FIFO and counts issued shifts (saturating).
module alu_shift_issue #(
    parameter logic [4:0] OP_SLL = 5'b00100,
    parameter logic [4:0] OP_SRA = 5'b00101,
    parameter int         CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    alu_shift_issue_if.slave bus,
    output logic [CNT_W-1:0] shift_count
);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  shiftamt;
        logic        shift_in;
        logic        dir;
        logic        is_shift;
    } entry_t;

    logic [1:0]       count_q, count_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] shift_count_q, shift_count_d;

    logic   push;
    logic   pop;
    entry_t dec;

    assign push = bus.in_valid & in_ready_q;
    assign pop  = out_valid_q & bus.out_ready;

    always_comb begin
        dec      = '0;
        dec.data = bus.in_a;
        if (bus.in_op == OP_SLL) begin
            dec.shiftamt = bus.in_shamt;
            dec.is_shift = 1'b1;
        end else if (bus.in_op == OP_SRA) begin
            dec.shiftamt = bus.in_shamt;
            dec.shift_in = bus.in_a[31];
            dec.dir      = 1'b1;
            dec.is_shift = 1'b1;
        end
    end

    // Head is the output register; it keeps its last value whenever the FIFO drains.
    always_comb begin
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        shift_count_d = shift_count_q;

        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = dec;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                case ({push, pop})
                    2'b11: head_d = dec;
                    2'b10: begin
                        tail_d  = dec;
                        count_d = 2'd2;
                    end
                    2'b01: count_d = 2'd0;
                    default: ;
                endcase
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase

        out_valid_d = (count_d != 2'd0);
        in_ready_d  = (count_d < 2'd2);

        if (pop && head_q.is_shift && !(&shift_count_q)) begin
            shift_count_d = shift_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q       <= 2'd0;
            head_q        <= '0;
            tail_q        <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            shift_count_q <= '0;
        end else begin
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            shift_count_q <= shift_count_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = head_q.data;
    assign bus.out_shiftamt = head_q.shiftamt;
    assign bus.out_shift_in = head_q.shift_in;
    assign bus.out_dir      = head_q.dir;
    assign bus.out_is_shift = head_q.is_shift;
    assign shift_count      = shift_count_q;

endmodule

// File: tb/tb_alu_shift_issue.sv
// Directed bench for alu_shift_issue: decode, latency, backpressure, async reset
// and counter saturation, with hand-computed expected values.
module tb_alu_shift_issue;

    localparam logic [4:0] SLL = 5'b00100;
    localparam logic [4:0] SRA = 5'b00101;
    localparam logic [4:0] ADD = 5'b00000;

    logic       clock;
    logic       reset_n;
    logic [3:0] shift_count;
    int         checks;
    int         errors;

    alu_shift_issue_if bus();

    alu_shift_issue #(.CNT_W(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .shift_count (shift_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then land 1ns after the edge that consumed them.
    task automatic applyStimulus(input logic valid, input logic [4:0] op, input logic [31:0] a,
                                 input logic [4:0] shamt, input logic rdy);
        bus.in_valid  = valid;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_shamt  = shamt;
        bus.out_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_shamt  = '0;
        bus.out_ready = 1'b0;
        #12;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_count", shift_count, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_shiftamt", bus.out_shiftamt, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // SLL
        applyStimulus(1, SLL, 32'h0000_00F1, 5'd4, 1);
        checkOutput("sll_valid", bus.out_valid, 1);
        checkOutput("sll_data", bus.out_data, 32'h0000_00F1);
        checkOutput("sll_shamt", bus.out_shiftamt, 4);
        checkOutput("sll_shift_in", bus.out_shift_in, 0);
        checkOutput("sll_dir", bus.out_dir, 0);
        checkOutput("sll_is_shift", bus.out_is_shift, 1);
        checkOutput("sll_count_pre", shift_count, 0);
        applyStimulus(0, ADD, 32'h0, 5'd0, 1);
        checkOutput("sll_count_post", shift_count, 1);
        checkOutput("sll_drained", bus.out_valid, 0);

        // SRA, negative then positive operand back to back
        applyStimulus(1, SRA, 32'h8000_0000, 5'd31, 1);
        checkOutput("sra_neg_shift_in", bus.out_shift_in, 1);
        checkOutput("sra_neg_dir", bus.out_dir, 1);
        checkOutput("sra_neg_shamt", bus.out_shiftamt, 31);
        applyStimulus(1, SRA, 32'h7FFF_FFFF, 5'd3, 1);
        checkOutput("sra_pos_valid", bus.out_valid, 1);
        checkOutput("sra_pos_data", bus.out_data, 32'h7FFF_FFFF);
        checkOutput("sra_pos_shift_in", bus.out_shift_in, 0);
        checkOutput("sra_pos_dir", bus.out_dir, 1);
        checkOutput("sra_pos_shamt", bus.out_shiftamt, 3);
        checkOutput("sra_count_mid", shift_count, 2);
        applyStimulus(0, ADD, 32'h0, 5'd0, 1);
        checkOutput("sra_count", shift_count, 3);

        // Non-shift op passes A and does not count
        applyStimulus(1, ADD, 32'h1234_5678, 5'd7, 1);
        checkOutput("add_data", bus.out_data, 32'h1234_5678);
        checkOutput("add_shamt", bus.out_shiftamt, 0);
        checkOutput("add_is_shift", bus.out_is_shift, 0);
        checkOutput("add_dir", bus.out_dir, 0);
        applyStimulus(0, ADD, 32'h0, 5'd0, 1);
        checkOutput("add_count", shift_count, 3);

        // Backpressure: third beat must be refused, head stable, then ordered drain
        applyStimulus(1, SLL, 32'h0000_0001, 5'd1, 0);
        checkOutput("bp_in_ready_1", bus.in_ready, 1);
        checkOutput("bp_head_1", bus.out_data, 32'h1);
        applyStimulus(1, SRA, 32'h0000_0002, 5'd2, 0);
        checkOutput("bp_in_ready_full", bus.in_ready, 0);
        checkOutput("bp_head_2", bus.out_data, 32'h1);
        applyStimulus(1, ADD, 32'h0000_0003, 5'd3, 0);
        checkOutput("bp_in_ready_third", bus.in_ready, 0);
        checkOutput("bp_head_stable", bus.out_data, 32'h1);
        checkOutput("bp_shamt_stable", bus.out_shiftamt, 1);
        checkOutput("bp_count_hold", shift_count, 3);
        applyStimulus(0, ADD, 32'h0, 5'd0, 1);
        checkOutput("bp_second_data", bus.out_data, 32'h2);
        checkOutput("bp_second_dir", bus.out_dir, 1);
        checkOutput("bp_in_ready_back", bus.in_ready, 1);
        checkOutput("bp_count_a", shift_count, 4);
        applyStimulus(0, ADD, 32'h0, 5'd0, 1);
        checkOutput("bp_drained", bus.out_valid, 0);
        checkOutput("bp_count_b", shift_count, 5);

        // Async reset with two beats buffered
        applyStimulus(1, SLL, 32'hAAAA_0001, 5'd1, 0);
        applyStimulus(1, SLL, 32'hAAAA_0002, 5'd2, 0);
        checkOutput("mid_full", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", bus.out_valid, 0);
        checkOutput("mid_rst_in_ready", bus.in_ready, 1);
        checkOutput("mid_rst_count", shift_count, 0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(0, ADD, 32'h0, 5'd0, 1);
        applyStimulus(0, ADD, 32'h0, 5'd0, 1);
        checkOutput("mid_no_stale", bus.out_valid, 0);
        checkOutput("mid_count_post", shift_count, 0);

        // Saturation: 17 streamed SLL beats on a 4-bit counter
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(1, SLL, 32'(k), 5'd1, 1);
            if (k == 15) checkOutput("sat_count_14", shift_count, 14);
        end
        applyStimulus(0, ADD, 32'h0, 5'd0, 1);
        checkOutput("sat_count_max", shift_count, 4'hF);
        applyStimulus(1, SLL, 32'h55, 5'd1, 1);
        applyStimulus(0, ADD, 32'h0, 5'd0, 1);
        checkOutput("sat_count_hold", shift_count, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
